cache_mem_arbiter: RTL and testbench

Shares the single 256-bit burst-memory port (bmem) between the instruction cache and the data cache once the caches are integrated into the core. Each cache issues one line request at a time. The arbiter grants one cache, forwards its request to bmem, holds it until bmem responds, then returns the line and a one-cycle response pulse to the granted cache. Simultaneous requests are granted round-robin, so neither fetch nor load/store traffic can starve.

---
 rtl/cache_mem_arbiter_pkg.sv | 25 ++
 rtl/cache_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared core types: arbiter FSM states, grant owner, and the round-robin tie-break.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    // On a tie the cache that did not win last time gets the port.
    function automatic arb_grant_t rr_select(input logic iReq, input logic dReq,
                                             input arb_grant_t lastGrant);
        if (iReq && (!dReq || lastGrant == GRANT_D)) begin
            return GRANT_I;
        end
        return GRANT_D;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing the single burst-memory port between icache and dcache.
// All outputs are registered; one line transaction is in flight at a time.
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [LINE_WIDTH-1:0] bmem_wdata,
    input  logic [LINE_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_resp
);

    arb_state_t            state_q, state_d;
    arb_grant_t            lastGrant_q, lastGrant_d;
    logic [ADDR_WIDTH-1:0] bmemAddr_q, bmemAddr_d;
    logic                  bmemRead_q, bmemRead_d;
    logic                  bmemWrite_q, bmemWrite_d;
    logic [LINE_WIDTH-1:0] bmemWdata_q, bmemWdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  iResp_q, iResp_d;
    logic                  dResp_q, dResp_d;

    logic iReq;
    logic dReq;

    assign iReq = i_read;
    assign dReq = d_read | d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_D;
            bmemAddr_q  <= '0;
            bmemRead_q  <= 1'b0;
            bmemWrite_q <= 1'b0;
            bmemWdata_q <= '0;
            rdata_q     <= '0;
            iResp_q     <= 1'b0;
            dResp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            bmemAddr_q  <= bmemAddr_d;
            bmemRead_q  <= bmemRead_d;
            bmemWrite_q <= bmemWrite_d;
            bmemWdata_q <= bmemWdata_d;
            rdata_q     <= rdata_d;
            iResp_q     <= iResp_d;
            dResp_q     <= dResp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        bmemAddr_d  = bmemAddr_q;
        bmemRead_d  = bmemRead_q;
        bmemWrite_d = bmemWrite_q;
        bmemWdata_d = bmemWdata_q;
        rdata_d     = rdata_q;
        iResp_d     = 1'b0;
        dResp_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (iReq || dReq) begin
                    if (rr_select(iReq, dReq, lastGrant_q) == GRANT_I) begin
                        state_d     = SERVE_I;
                        lastGrant_d = GRANT_I;
                        bmemAddr_d  = i_addr;
                        bmemRead_d  = 1'b1;
                        bmemWrite_d = 1'b0;
                    end else begin
                        // Read+write together is illegal; the write wins.
                        state_d     = SERVE_D;
                        lastGrant_d = GRANT_D;
                        bmemAddr_d  = d_addr;
                        bmemRead_d  = d_read & ~d_write;
                        bmemWrite_d = d_write;
                        bmemWdata_d = d_wdata;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (bmem_resp) begin
                    state_d     = DONE;
                    rdata_d     = bmem_rdata;
                    bmemRead_d  = 1'b0;
                    bmemWrite_d = 1'b0;
                    iResp_d     = (state_q == SERVE_I);
                    dResp_d     = (state_q == SERVE_D);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write));
        end
    end

    assign i_rdata    = rdata_q;
    assign d_rdata    = rdata_q;
    assign i_resp     = iResp_q;
    assign d_resp     = dResp_q;
    assign bmem_addr  = bmemAddr_q;
    assign bmem_read  = bmemRead_q;
    assign bmem_write = bmemWrite_q;
    assign bmem_wdata = bmemWdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with hand-computed expectations.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_addr;
    logic          i_read;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [AW-1:0] d_addr;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [LW-1:0] bmem_wdata;
    logic [LW-1:0] bmem_rdata;
    logic          bmem_resp;

    int vectors;
    int miscompares;

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it; inputs set here land on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; bmem_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; bmem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got %b want 0000", {bmem_read, bmem_write, i_resp, d_resp});
        end
        vectors++;
        if (i_rdata !== '0 || bmem_addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got rdata=%h addr=%h want 0", i_rdata, bmem_addr);
        end
    endtask

    task automatic test_lone_icache();
        i_addr = 32'h6000_0040; i_read = 1;
        tick();
        vectors++;
        if (bmem_read !== 1'b1 || bmem_write !== 1'b0 || bmem_addr !== 32'h6000_0040) begin
            miscompares++;
            $display("[TB] FAIL icache_issue got rd=%b wr=%b addr=%h want 1 0 60000040", bmem_read, bmem_write, bmem_addr);
        end
        bmem_resp = 1; bmem_rdata = {32{8'hA5}};
        tick();
        bmem_resp = 0; bmem_rdata = '0; i_read = 0;
        vectors++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== {32{8'hA5}}) begin
            miscompares++;
            $display("[TB] FAIL icache_resp got i=%b d=%b rdata=%h want 1 0 a5..", i_resp, d_resp, i_rdata);
        end
        vectors++;
        if (bmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL icache_drop got rd=%b want 0", bmem_read);
        end
        tick();
        vectors++;
        if (i_resp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL icache_pulse got i_resp=%b want 0", i_resp);
        end
        tick();
    endtask

    task automatic test_lone_dcache_write();
        d_addr = 32'h6000_1000; d_wdata = {8{32'h1234_5678}}; d_write = 1;
        tick();
        vectors++;
        if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_addr !== 32'h6000_1000
            || bmem_wdata !== {8{32'h1234_5678}}) begin
            miscompares++;
            $display("[TB] FAIL dwrite_issue got wr=%b rd=%b addr=%h wdata=%h", bmem_write, bmem_read, bmem_addr, bmem_wdata);
        end
        bmem_resp = 1; bmem_rdata = {32{8'h3C}};
        tick();
        bmem_resp = 0; d_write = 0;
        vectors++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || bmem_write !== 1'b0 || d_rdata !== {32{8'h3C}}) begin
            miscompares++;
            $display("[TB] FAIL dwrite_resp got d=%b i=%b wr=%b rdata=%h want 1 0 0 3c..", d_resp, i_resp, bmem_write, d_rdata);
        end
        tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] expAddr [3];
        expAddr[0] = 32'h6000_0100; expAddr[1] = 32'h6000_0200; expAddr[2] = 32'h6000_0100;
        rst = 1; tick(); rst = 0;
        i_addr = 32'h6000_0100; d_addr = 32'h6000_0200; i_read = 1; d_read = 1; d_write = 0;
        for (int r = 0; r < 3; r++) begin
            tick();
            vectors++;
            if (bmem_read !== 1'b1 || bmem_addr !== expAddr[r]) begin
                miscompares++;
                $display("[TB] FAIL rr_grant%0d got rd=%b addr=%h want 1 %h", r, bmem_read, bmem_addr, expAddr[r]);
            end
            bmem_resp = 1; bmem_rdata = {8{32'(r)}};
            tick();
            bmem_resp = 0;
            vectors++;
            if (i_resp !== (r != 1) || d_resp !== (r == 1)) begin
                miscompares++;
                $display("[TB] FAIL rr_resp%0d got i=%b d=%b want %b %b", r, i_resp, d_resp, r != 1, r == 1);
            end
            tick();
        end
        i_read = 0; d_read = 0;
        tick();
    endtask

    task automatic test_held_through_done();
        i_addr = 32'h6000_0300; i_read = 1;
        tick();
        bmem_resp = 1;
        tick();
        bmem_resp = 0;
        vectors++;
        if (i_resp !== 1'b1 || bmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_resp got i=%b rd=%b want 1 0", i_resp, bmem_read);
        end
        tick();
        vectors++;
        if (bmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_done got rd=%b want 0", bmem_read);
        end
        i_read = 0;
        tick();
        vectors++;
        if (bmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_regrant got rd=%b want 0", bmem_read);
        end
    endtask

    task automatic test_spurious_resp();
        bmem_resp = 1; bmem_rdata = {32{8'hEE}};
        tick();
        bmem_resp = 0;
        tick();
        vectors++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0 || bmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL spurious got i=%b d=%b rd=%b want 0 0 0", i_resp, d_resp, bmem_read);
        end
        tick();
        vectors++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL spurious_late got i=%b d=%b want 0 0", i_resp, d_resp);
        end
    endtask

    task automatic test_reset_mid_serve();
        d_addr = 32'h6000_2000; d_read = 1;
        tick();
        vectors++;
        if (bmem_read !== 1'b1 || bmem_addr !== 32'h6000_2000) begin
            miscompares++;
            $display("[TB] FAIL rst_setup got rd=%b addr=%h want 1 60002000", bmem_read, bmem_addr);
        end
        rst = 1;
        tick();
        rst = 0; d_read = 0;
        vectors++;
        if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || bmem_addr !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid got rd=%b wr=%b addr=%h want 0 0 0", bmem_read, bmem_write, bmem_addr);
        end
        bmem_resp = 1;
        tick();
        bmem_resp = 0;
        vectors++;
        if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_drop got d=%b i=%b want 0 0", d_resp, i_resp);
        end
        tick();
        vectors++;
        if (d_resp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_drop_late got d=%b want 0", d_resp);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_lone_icache();
        test_lone_dcache_write();
        test_round_robin();
        test_held_through_done();
        test_spurious_resp();
        test_reset_mid_serve();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
